// File: rtl/sdiv_sched_pkg.sv
// sdiv_sched_pkg: state encoding and constants for the shared-divider scheduler.
// Divide-by-zero saturation constants are used when SDIV_SCHED_DIV0_CHK_EN is set.
package sdiv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_t;

  localparam int DEF_WIDTH = 16;

  localparam logic [DEF_WIDTH-1:0] QSAT_POS =
    {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] QSAT_NEG =
    {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Search starts one past last_idx and wraps; first set req bit wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_idx,
  output logic               gnt_valid,
  output logic [IW-1:0]      gnt_idx
);

  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

  logic [IW:0] cand;

  // Walk from lowest to highest priority so the best match is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, last_idx} + (IW+1)'(k);
      if (cand >= NR) begin
        cand = cand - NR;
      end
      if (req[cand[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sdiv_sched.sv
// sdiv_sched: round-robin scheduler sharing one SDiv among NUM_REQ requesters.
// Define SDIV_SCHED_DIV0_CHK_EN to trap zero divisors without starting SDiv.
module sdiv_sched
  import sdiv_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0]   divisor_in,
  output logic [NUM_REQ-1:0]         done,
  output logic [WIDTH-1:0]           quotient_out,
  output logic                       err,
  output logic                       busy,
  output logic                       div_go,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_rdy,
  input  logic [WIDTH-1:0]           div_quotient
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_t state;
  sched_state_t state_nxt;

  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] last_idx;
  logic          armed;
  logic          res_take;
  logic          grant;

  logic [WIDTH-1:0] dvd [NUM_REQ];
  logic [WIDTH-1:0] dvs [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dvd[i] = dividend_in[i*WIDTH +: WIDTH];
    assign dvs[i] = divisor_in[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (req),
    .last_idx  (last_idx),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant = (state == IDLE) && gnt_valid;

  // armed is low in the first WAIT cycle, masking a stale rdy.
  assign res_take = (state == WAIT) && armed && div_rdy;

`ifdef SDIV_SCHED_DIV0_CHK_EN
  localparam logic [WIDTH-1:0] SAT_POS =
    (WIDTH == DEF_WIDTH) ? QSAT_POS
                         : {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG =
    (WIDTH == DEF_WIDTH) ? QSAT_NEG
                         : {1'b1, {(WIDTH-1){1'b0}}};

  logic div0;
  assign div0 = (dvs[gnt_idx] == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
`ifdef SDIV_SCHED_DIV0_CHK_EN
          state_nxt = div0 ? RESP : LAUNCH;
`else
          state_nxt = LAUNCH;
`endif
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (armed && div_rdy) begin
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_go = 1'b0;
    busy   = 1'b1;
    done   = '0;
    unique case (1'b1)
      (state == IDLE):   busy = 1'b0;
      (state == LAUNCH): div_go = 1'b1;
      (state == WAIT):   ;
      (state == RESP):   done[gnt_q] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      gnt_q        <= '0;
      last_idx     <= IW'(NUM_REQ-1);
      div_dividend <= '0;
      div_divisor  <= '0;
      quotient_out <= '0;
    end else begin
      armed <= (state == WAIT);
      if (grant) begin
        gnt_q        <= gnt_idx;
        last_idx     <= gnt_idx;
        div_dividend <= dvd[gnt_idx];
        div_divisor  <= dvs[gnt_idx];
`ifdef SDIV_SCHED_DIV0_CHK_EN
        if (div0) begin
          quotient_out <= dvd[gnt_idx][WIDTH-1]
                          ? SAT_NEG : SAT_POS;
        end
`endif
      end
      if (res_take) begin
        quotient_out <= div_quotient;
      end
    end
  end

`ifdef SDIV_SCHED_DIV0_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (grant) begin
      err <= div0;
    end else if (res_take) begin
      err <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdiv_sched.sv
// tb_sdiv_sched: directed + random bench for sdiv_sched with a behavioural SDiv.
// Expectations are adjusted when SDIV_SCHED_DIV0_CHK_EN is defined.
module tb_sdiv_sched;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [W-1:0]   dvd [N];
  logic [W-1:0]   dvs [N];
  logic [N*W-1:0] dividend_in;
  logic [N*W-1:0] divisor_in;

  logic [N-1:0]   done;
  logic [W-1:0]   quotient_out;
  logic           err;
  logic           busy;
  logic           div_go;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_rdy;
  logic [W-1:0]   div_quotient;

  int total = 0;
  int bad   = 0;
  int last  = N-1;

  always #5 clk = ~clk;

  always_comb begin
    dividend_in = '0;
    divisor_in  = '0;
    for (int i = 0; i < N; i++) begin
      dividend_in[i*W +: W] = dvd[i];
      divisor_in[i*W +: W]  = dvs[i];
    end
  end

  sdiv_sched #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .dividend_in  (dividend_in),
    .divisor_in   (divisor_in),
    .done         (done),
    .quotient_out (quotient_out),
    .err          (err),
    .busy         (busy),
    .div_go       (div_go),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_rdy      (div_rdy),
    .div_quotient (div_quotient)
  );

  // SDiv stand-in: rdy idles high, drops one edge after go, rises L edges after go.
  function automatic logic [W-1:0] mock_div(logic [W-1:0] a, logic [W-1:0] b);
    int ai;
    int bi;
    int qi;
    if (b == '0) return '1;
    ai = $signed(a);
    bi = $signed(b);
    qi = ai / bi;
    return qi[W-1:0];
  endfunction

  int mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_rdy      <= 1'b1;
      div_quotient <= '0;
      mcnt         <= 0;
    end else if (div_go) begin
      mcnt <= L;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == L) div_rdy <= 1'b0;
      if (mcnt == 1) begin
        div_rdy      <= 1'b1;
        div_quotient <= mock_div(div_dividend, div_divisor);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Truncating signed division from magnitudes and signs.
  function automatic logic [W-1:0] ref_q(logic [W-1:0] a, logic [W-1:0] b);
    int ai;
    int bi;
    int qa;
    ai = $signed(a);
    bi = $signed(b);
    qa = (ai < 0 ? -ai : ai) / (bi < 0 ? -bi : bi);
    if ((ai < 0) != (bi < 0)) qa = -qa;
    return qa[W-1:0];
  endfunction

  task automatic wait_done(input logic [N-1:0] late,
                           output logic [N-1:0] d, output int cyc,
                           output int gos, output bit got);
    got = 1'b0;
    gos = 0;
    cyc = 0;
    d   = '0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clk);
      if (c == 3) req = req | late;
      if (div_go) gos++;
      if (done != '0) begin
        got = 1'b1;
        d   = done;
        cyc = c;
      end
    end
  endtask

  task automatic do_op(input string tag, input int lat,
                       input logic [N-1:0] late);
    int ei;
    logic [W-1:0] eq;
    logic ee;
    int eg;
    logic [N-1:0] ed;
    logic [N-1:0] d;
    int cyc;
    int gos;
    bit got;
    ei = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req[i] && ei < 0) ei = i;
    end
    last = ei;
    ed = '0;
    ed[ei] = 1'b1;
    ee = 1'b0;
    eg = 1;
`ifdef SDIV_SCHED_DIV0_CHK_EN
    if (dvs[ei] == '0) begin
      eq = dvd[ei][W-1] ? 16'h8000 : 16'h7FFF;
      ee = 1'b1;
      eg = 0;
    end else begin
      eq = ref_q(dvd[ei], dvs[ei]);
    end
`else
    eq = (dvs[ei] == '0) ? '1 : ref_q(dvd[ei], dvs[ei]);
`endif
    wait_done(late, d, cyc, gos, got);
    chk({tag, "_seen"}, 32'(got), 32'd1);
    chk({tag, "_done"}, 32'(d), 32'(ed));
    chk({tag, "_q"}, 32'(quotient_out), 32'(eq));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    chk({tag, "_go"}, gos, eg);
    if (lat >= 0) chk({tag, "_lat"}, cyc, lat);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < N; i++) begin
      dvd[i] = '0;
      dvs[i] = 16'd1;
    end
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_go", 32'(div_go), 32'd0);
    chk("rst_dvd", 32'(div_dividend), 32'd0);
    chk("rst_dvs", 32'(div_divisor), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    dvd[0] = 16'hFFF8;
    dvs[0] = 16'd2;
    req = 4'b0001;
    do_op("single", L+3, '0);
    req = '0;

    dvd[0] = 16'd100;
    dvs[0] = 16'd7;
    dvd[1] = 16'd9;
    dvs[1] = 16'd3;
    dvd[3] = -16'sd21;
    dvs[3] = 16'd4;
    req = 4'b1011;
    repeat (5) do_op("rr", -1, '0);
    req = '0;
    @(negedge clk);

    dvd[2] = -16'sd5;
    dvs[2] = 16'd0;
`ifdef SDIV_SCHED_DIV0_CHK_EN
    req = 4'b0100;
    do_op("div0", 1, '0);
`else
    req = 4'b0100;
    do_op("div0", L+3, '0);
`endif
    req = '0;

    dvd[0] = 16'd50;
    dvs[0] = 16'd5;
    dvd[2] = 16'd77;
    dvs[2] = 16'd7;
    req = 4'b0101;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (div_go) seen = 1'b1;
    end
    chk("rst_launch", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_go", 32'(div_go), 32'd0);
    chk("mid_q", 32'(quotient_out), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    chk("mid_dvd", 32'(div_dividend), 32'd0);
    chk("mid_dvs", 32'(div_divisor), 32'd0);
    @(negedge clk);
    chk("mid_done2", 32'(done), 32'd0);
    rst_n = 1'b1;
    last = N-1;
    do_op("reserve", L+3, '0);
    req = '0;
    @(negedge clk);

    dvd[0] = 16'd1000;
    dvs[0] = -16'sd9;
    dvd[2] = -16'sd300;
    dvs[2] = 16'd7;
    req = 4'b0001;
    do_op("late0", L+3, 4'b0100);
    req = 4'b0100;
    do_op("late2", L+3, '0);
    req = '0;

    for (int n = 0; n < 40; n++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        dvd[i] = W'($urandom);
        if ($urandom_range(0, 5) == 0) dvs[i] = '0;
        else if ($urandom_range(0, 1) == 1) dvs[i] = W'($urandom);
        else dvs[i] = W'($urandom_range(1, 20));
        if (dvd[i] == 16'h8000 && dvs[i] == 16'hFFFF) dvd[i] = 16'd1;
      end
      do_op("rnd", -1, '0);
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
